switch_debouncer: RTL and testbench

//   Conditions raw slide-switch inputs before the switch-to-LED path consumes them.

---
 rtl/switch_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 110 +++++++++++
 rtl/switch_debouncer.sv | 39 +++
 tb/tb_switch_debouncer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// +--------------------------------------------------------------------+
// | switch_pkg: shared state encoding and default sizing for the       |
// | switch debouncer.                                                  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package switch_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } bit_state_e;

   localparam int DEFAULT_WIDTH           = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// +--------------------------------------------------------------------+
// | debounce_bit: 2-flop synchroniser plus counter FSM for one switch. |
// | Optional edge pulses built when SW_EDGE_PULSE_EN is defined.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module debounce_bit
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_out,
   output logic busy,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   bit_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             mismatch;
   logic             accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      out_d    = out_q;
      accept   = 1'b0;
      mismatch = s2_q ^ out_q;
      if (state_q == ST_STABLE) begin
         if (mismatch) begin
            state_d = ST_CHECK;
            cnt_d   = CNT_W'(1);
         end
      end else begin
         // Any return to the accepted level drops back and restarts the count.
         if (!mismatch) begin
            state_d = ST_STABLE;
         end else if (cnt_q == CNT_MAX) begin
            state_d = ST_STABLE;
            out_d   = s2_q;
            accept  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      busy_d = (state_d == ST_CHECK);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= sw_in;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign sw_out = out_q;
   assign busy   = busy_q;

`ifdef SW_EDGE_PULSE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      rise_d = accept & s2_q;
      fall_d = accept & ~s2_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign rise          = 1'b0;
   assign fall          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// +--------------------------------------------------------------------+
// | switch_debouncer: WIDTH independent synchronise-and-debounce lanes.|
// | SW_RISE/SW_FALL are live only when SW_EDGE_PULSE_EN is defined.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH           = DEFAULT_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] SW_IN,
   output logic [WIDTH-1:0] SW_OUT,
   output logic [WIDTH-1:0] SW_BUSY,
   output logic [WIDTH-1:0] SW_RISE,
   output logic [WIDTH-1:0] SW_FALL
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .clk   (CLOCK_50),
         .rst_n (RESET_N),
         .sw_in (SW_IN[i]),
         .sw_out(SW_OUT[i]),
         .busy  (SW_BUSY[i]),
         .rise  (SW_RISE[i]),
         .fall  (SW_FALL[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// +--------------------------------------------------------------------+
// | tb_switch_debouncer: directed bench for switch_debouncer with      |
// | WIDTH=4, DEBOUNCE_CYCLES=4; honours SW_EDGE_PULSE_EN.              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_switch_debouncer;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_in;
   logic [3:0] sw_out, sw_busy, sw_rise, sw_fall;

   int errors = 0;
   int checks = 0;

`ifdef SW_EDGE_PULSE_EN
   localparam logic PE = 1'b1;
`else
   localparam logic PE = 1'b0;
`endif

   switch_debouncer #(
      .WIDTH          (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLOCK_50(clk),
      .RESET_N (rst_n),
      .SW_IN   (sw_in),
      .SW_OUT  (sw_out),
      .SW_BUSY (sw_busy),
      .SW_RISE (sw_rise),
      .SW_FALL (sw_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy_seen;
      int bad_out;
      int rise_cnt;
      int fall_cnt;

      // 1: reset with all switches high
      rst_n = 1'b0;
      sw_in = 4'b1111;
      repeat (3) tick();
      check("rst_out",  sw_out,  4'b0000);
      check("rst_busy", sw_busy, 4'b0000);
      check("rst_rise", sw_rise, 4'b0000);
      check("rst_fall", sw_fall, 4'b0000);

      // 2: first level acceptance, 6 edges inclusive
      rst_n = 1'b1;
      sw_in = 4'b0001;
      repeat (5) tick();
      check("t2_out_early", sw_out, 4'b0000);
      check("t2_busy",      sw_busy, 4'b0001);
      tick();
      check("t2_out",  sw_out,  4'b0001);
      check("t2_rise", sw_rise, PE ? 4'b0001 : 4'b0000);
      check("t2_fall", sw_fall, 4'b0000);
      tick();
      check("t2_rise_clr", sw_rise, 4'b0000);

      // 3: 3-cycle glitch on bit 1 must be rejected
      sw_in     = 4'b0011;
      busy_seen = 0;
      bad_out   = 0;
      rise_cnt  = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 3) sw_in = 4'b0001;
         if (sw_busy[1]) busy_seen++;
         if (sw_out[1]) bad_out++;
         if (sw_rise[1]) rise_cnt++;
      end
      check("t3_busy_seen", (busy_seen > 0), 1);
      check("t3_busy_clr",  sw_busy, 4'b0000);
      check("t3_out_held",  bad_out, 0);
      check("t3_no_rise",   rise_cnt, 0);
      check("t3_out",       sw_out, 4'b0001);

      // 4: bounce on bit 2, final rise captured at edge 5
      rise_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         case (k)
            1, 3, 5: sw_in = 4'b0101;
            2, 4:    sw_in = 4'b0001;
            default: sw_in = 4'b0101;
         endcase
         tick();
         if (sw_rise[2]) rise_cnt++;
         if (k == 9)  check("t4_out_early", sw_out, 4'b0001);
         if (k == 10) check("t4_out",       sw_out, 4'b0101);
      end
      check("t4_rise_cnt", rise_cnt, PE ? 1 : 0);

      // 5: return to 0001, then flip every bit at once
      sw_in    = 4'b0001;
      fall_cnt = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (sw_fall[2]) fall_cnt++;
      end
      check("t5_pre_out",  sw_out, 4'b0001);
      check("t5_pre_fall", fall_cnt, PE ? 1 : 0);
      sw_in = 4'b1110;
      repeat (5) tick();
      check("t5_out_early", sw_out, 4'b0001);
      tick();
      check("t5_out",  sw_out,  4'b1110);
      check("t5_rise", sw_rise, PE ? 4'b1110 : 4'b0000);
      check("t5_fall", sw_fall, PE ? 4'b0001 : 4'b0000);
      tick();
      check("t5_rise_clr", sw_rise, 4'b0000);
      check("t5_fall_clr", sw_fall, 4'b0000);

      // 6: reset while bit 3 is mid-count (cnt=2 after edge 4)
      sw_in = 4'b0110;
      repeat (4) tick();
      check("t6_busy_mid", sw_busy, 4'b1000);
      check("t6_out_mid",  sw_out,  4'b1110);
      rst_n = 1'b0;
      tick();
      check("t6_rst_out",  sw_out,  4'b0000);
      check("t6_rst_busy", sw_busy, 4'b0000);
      check("t6_rst_rise", sw_rise, 4'b0000);
      check("t6_rst_fall", sw_fall, 4'b0000);
      rst_n = 1'b1;
      repeat (5) tick();
      check("t6_restart_early", sw_out, 4'b0000);
      tick();
      check("t6_restart_out",  sw_out,  4'b0110);
      check("t6_restart_rise", sw_rise, PE ? 4'b0110 : 4'b0000);
      check("t6_restart_fall", sw_fall, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
